// File: rtl/fusion_pkg.sv
// fusion_pkg
//   Shared constants and helpers for the fusion shift accumulator.
//   - NUM_BRICKS / NUM_HALF : 16 bitbricks of a 4x4 array, grouped into 8 half-rows
//   - ROW_CODE_W            : width of a per-brick row shift code (shift 0..7)
//   - BIG_CODE_W            : width of a per-half-row big_shift code
//   - BIG_SHIFT_UNIT        : bit distance represented by one step of a big_shift code
//   - PIPE_STAGES           : registered stages between an accepted beat and out_valid
//   - decode_brick()        : brick index -> row / col / half-row position
package fusion_pkg;

   localparam int NUM_BRICKS     = 16;
   localparam int NUM_HALF       = NUM_BRICKS / 2;
   localparam int ROW_CODE_W     = 3;
   localparam int BIG_CODE_W     = 2;
   localparam int BIG_SHIFT_UNIT = 4;
   localparam int PIPE_STAGES    = 2;

   typedef struct packed {
      logic [1:0] row;
      logic [1:0] col;
      logic [2:0] half;
   } brick_pos_t;

   // Brick b = row*4 + col; half-row h = 2*row + (col >> 1).
   function automatic brick_pos_t decode_brick(input logic [3:0] idx);
      brick_pos_t pos;
      pos.row  = idx[3:2];
      pos.col  = idx[1:0];
      pos.half = {idx[3:2], idx[1]};
      return pos;
   endfunction

endpackage

// File: rtl/brick_shift_reduce.sv
// brick_shift_reduce
//   Combinational first-stage datapath: shifts each of the 16 signed bitbrick
//   products by its row code, sums pairs of bricks into 8 half-row terms and
//   shifts each half-row term by BIG_SHIFT_UNIT * its big_shift code.
//   Ports:
//     products   in  16*PROD_W  brick b at [b*PROD_W +: PROD_W], signed
//     row0..row3 in  12 each     row r codes; col c at [3c+2:3c]
//     big_shift  in  16          half-row h code at [2h+1:2h]
//     half_terms out 8 x ACC_W   shifted half-row sums (two's complement)
module brick_shift_reduce
   import fusion_pkg::*;
#(
   parameter int PROD_W = 6,
   parameter int ACC_W  = 32
) (
   input  logic [NUM_BRICKS*PROD_W-1:0]     products,
   input  logic [4*ROW_CODE_W-1:0]          row0,
   input  logic [4*ROW_CODE_W-1:0]          row1,
   input  logic [4*ROW_CODE_W-1:0]          row2,
   input  logic [4*ROW_CODE_W-1:0]          row3,
   input  logic [NUM_HALF*BIG_CODE_W-1:0]   big_shift,
   output logic [NUM_HALF-1:0][ACC_W-1:0]   half_terms
);

   logic [3:0][4*ROW_CODE_W-1:0]     row_codes;
   logic [NUM_BRICKS-1:0][ACC_W-1:0] shifted;
   logic [NUM_HALF-1:0][ACC_W-1:0]   half_sum;

   assign row_codes = {row3, row2, row1, row0};

   always_comb begin
      brick_pos_t              pos;
      logic [PROD_W-1:0]       prod;
      logic [ACC_W-1:0]        ext;
      logic [ROW_CODE_W-1:0]   code;
      logic [BIG_CODE_W-1:0]   big_code;

      pos      = '0;
      prod     = '0;
      ext      = '0;
      code     = '0;
      big_code = '0;
      shifted  = '0;
      half_sum = '0;
      half_terms = '0;

      for (int b = 0; b < NUM_BRICKS; b++) begin
         pos  = decode_brick(4'(b));
         prod = products[b*PROD_W +: PROD_W];
         // Sign-extend before shifting so negative products keep their sign.
         ext  = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
         code = row_codes[pos.row][ROW_CODE_W*pos.col +: ROW_CODE_W];
         shifted[b] = ext << code;
         half_sum[pos.half] = half_sum[pos.half] + shifted[b];
      end

      for (int h = 0; h < NUM_HALF; h++) begin
         big_code      = big_shift[BIG_CODE_W*h +: BIG_CODE_W];
         half_terms[h] = half_sum[h] << (BIG_SHIFT_UNIT * big_code);
      end
   end

endmodule

// File: rtl/fusion_shift_accumulator.sv
// fusion_shift_accumulator
//   Applies row / big_shift codes to 16 bitbrick products, fuses them into one
//   value per beat and accumulates fused values over a first..last window.
//   Two registered stages: S1 holds the shifted half-row terms, S2 holds the
//   accumulator and the output register.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     in_valid/in_ready   input beat handshake
//     products            16 signed bricks, brick b at [b*PROD_W +: PROD_W]
//     row0..row3          per-brick row shift codes
//     big_shift           per-half-row shift codes
//     first/last          accumulation window delimiters
//     out_valid/out_ready output handshake
//     out_data            accumulated window sum (signed, wraps at ACC_W)
//
//   Handshake: a beat transfers on a cycle where valid && ready are both high
//   at the clock edge. A producer holds valid and its data until it transfers;
//   ready may change freely. The output holds out_data stable while
//   out_valid && !out_ready. A stalled output freezes the whole pipeline, so
//   in_ready drops in exactly those cycles.
module fusion_shift_accumulator
   import fusion_pkg::*;
#(
   parameter int PROD_W = 6,
   parameter int ACC_W  = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [NUM_BRICKS*PROD_W-1:0]   products,
   input  logic [4*ROW_CODE_W-1:0]        row0,
   input  logic [4*ROW_CODE_W-1:0]        row1,
   input  logic [4*ROW_CODE_W-1:0]        row2,
   input  logic [4*ROW_CODE_W-1:0]        row3,
   input  logic [NUM_HALF*BIG_CODE_W-1:0] big_shift,
   input  logic                           first,
   input  logic                           last,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [ACC_W-1:0]               out_data
);

   logic [NUM_HALF-1:0][ACC_W-1:0] half_terms;

   logic [NUM_HALF-1:0][ACC_W-1:0] s1_terms_q, s1_terms_d;
   logic                           s1_valid_q, s1_valid_d;
   logic                           s1_first_q, s1_first_d;
   logic                           s1_last_q,  s1_last_d;
   logic [ACC_W-1:0]               acc_q,      acc_d;
   logic                           out_valid_q, out_valid_d;
   logic [ACC_W-1:0]               out_data_q,  out_data_d;

   logic                           en;
   logic [ACC_W-1:0]               fused;
   logic [ACC_W-1:0]               window_sum;

   brick_shift_reduce #(
      .PROD_W (PROD_W),
      .ACC_W  (ACC_W)
   ) u_brick_shift_reduce (
      .products   (products),
      .row0       (row0),
      .row1       (row1),
      .row2       (row2),
      .row3       (row3),
      .big_shift  (big_shift),
      .half_terms (half_terms)
   );

   always_comb begin
      en          = !(out_valid_q && !out_ready);
      s1_terms_d  = s1_terms_q;
      s1_valid_d  = s1_valid_q;
      s1_first_d  = s1_first_q;
      s1_last_d   = s1_last_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      fused = '0;
      for (int h = 0; h < NUM_HALF; h++) begin
         fused = fused + s1_terms_q[h];
      end
      // A first beat restarts the window regardless of any stray partial sum.
      window_sum = (s1_first_q ? '0 : acc_q) + fused;

      if (en) begin
         s1_valid_d = in_valid;
         s1_first_d = first;
         s1_last_d  = last;
         if (in_valid) begin
            s1_terms_d = half_terms;
         end
      end

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      // A landing last result overrides the handshake clear, so back-to-back
      // results never drop one.
      if (en && s1_valid_q) begin
         acc_d = window_sum;
         if (s1_last_q) begin
            acc_d       = '0;
            out_valid_d = 1'b1;
            out_data_d  = window_sum;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_terms_q  <= '0;
         s1_valid_q  <= 1'b0;
         s1_first_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         s1_terms_q  <= s1_terms_d;
         s1_valid_q  <= s1_valid_d;
         s1_first_q  <= s1_first_d;
         s1_last_q   <= s1_last_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   // Ready is forced high while in reset so the upstream never sees a stall
   // caused by pre-reset output state.
   assign in_ready  = rst || en;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_fusion_shift_accumulator.sv
module tb_fusion_shift_accumulator;

   localparam int PROD_W = 6;
   localparam int ACC_W  = 32;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [16*PROD_W-1:0] products;
   logic [11:0]       row0, row1, row2, row3;
   logic [15:0]       big_shift;
   logic              first, last;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_data;

   int n_checks;
   int n_errors;

   fusion_shift_accumulator #(
      .PROD_W (PROD_W),
      .ACC_W  (ACC_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .products  (products),
      .row0      (row0),
      .row1      (row1),
      .row2      (row2),
      .row3      (row3),
      .big_shift (big_shift),
      .first     (first),
      .last      (last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   function automatic logic [16*PROD_W-1:0] fill(input logic [PROD_W-1:0] v);
      logic [16*PROD_W-1:0] r;
      r = '0;
      for (int b = 0; b < 16; b++) r[b*PROD_W +: PROD_W] = v;
      return r;
   endfunction

   // Advance one clock; inputs/outputs are touched 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [ACC_W-1:0] obs,
                        input logic [ACC_W-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_beat(input logic [16*PROD_W-1:0] p, input logic [11:0] rc,
                           input logic [15:0] bs, input logic f, input logic l);
      in_valid  = 1'b1;
      products  = p;
      row0      = rc;
      row1      = rc;
      row2      = rc;
      row3      = rc;
      big_shift = bs;
      first     = f;
      last      = l;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      first    = 1'b0;
      last     = 1'b0;
      products = '0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b1;
      out_ready = 1'b1;
      row0 = '0; row1 = '0; row2 = '0; row3 = '0;
      big_shift = '0;
      idle();

      // Reset state
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      rst = 1'b0;
      tick();
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // T1: all ones, codes 0, single-beat window -> 16 two cycles later
      set_beat(fill(6'd1), 12'h000, 16'h0000, 1'b1, 1'b1);
      tick();
      idle();
      check("t1_lat1_valid", 32'(out_valid), 32'd0);
      tick();
      check("t1_valid", 32'(out_valid), 32'd1);
      check("t1_data", out_data, 32'd16);
      tick();
      check("t1_cleared", 32'(out_valid), 32'd0);

      // T2: row codes all 2 -> 16 * 4 = 64
      set_beat(fill(6'd1), 12'h492, 16'h0000, 1'b1, 1'b1);
      tick();
      idle();
      tick();
      check("t2_valid", 32'(out_valid), 32'd1);
      check("t2_data", out_data, 32'd64);

      // T3: brick 15 = -1, row3 col3 code 6, big code 2 -> -(1<<14)
      set_beat('0, 12'h000, 16'h8000, 1'b1, 1'b1);
      products[15*PROD_W +: PROD_W] = 6'h3F;
      row3 = 12'hC00;
      tick();
      idle();
      row3 = '0;
      big_shift = '0;
      tick();
      check("t3_valid", 32'(out_valid), 32'd1);
      check("t3_data", out_data, 32'hFFFF_C000);

      // T4: 3-beat window of all twos -> 96, no output before the last
      set_beat(fill(6'd2), 12'h000, 16'h0000, 1'b1, 1'b0);
      tick();
      check("t4_b0_valid", 32'(out_valid), 32'd0);
      set_beat(fill(6'd2), 12'h000, 16'h0000, 1'b0, 1'b0);
      tick();
      check("t4_b1_valid", 32'(out_valid), 32'd0);
      set_beat(fill(6'd2), 12'h000, 16'h0000, 1'b0, 1'b1);
      tick();
      idle();
      check("t4_b2_valid", 32'(out_valid), 32'd0);
      tick();
      check("t4_valid", 32'(out_valid), 32'd1);
      check("t4_data", out_data, 32'd96);
      tick();

      // T5: no open window, bubble in between: 16 (+ bubble) + 32 = 48
      set_beat(fill(6'd1), 12'h000, 16'h0000, 1'b0, 1'b0);
      tick();
      idle();
      tick();
      tick();
      check("t5_bubble_valid", 32'(out_valid), 32'd0);
      set_beat(fill(6'd2), 12'h000, 16'h0000, 1'b0, 1'b1);
      tick();
      idle();
      tick();
      check("t5_valid", 32'(out_valid), 32'd1);
      check("t5_data", out_data, 32'd48);
      tick();

      // T6: negative products with big shift on every half-row:
      // 16 * (-2) << 4 = -512
      set_beat(fill(6'h3E), 12'h000, 16'h5555, 1'b1, 1'b1);
      tick();
      idle();
      big_shift = '0;
      tick();
      check("t6_data", out_data, 32'hFFFF_FE00);
      tick();

      // T7: stall with out_ready=0, then back-to-back results
      out_ready = 1'b0;
      set_beat(fill(6'd1), 12'h000, 16'h0000, 1'b1, 1'b1);   // A -> 16
      tick();
      set_beat(fill(6'd2), 12'h000, 16'h0000, 1'b1, 1'b1);   // B -> 32
      tick();
      set_beat(fill(6'd3), 12'h000, 16'h0000, 1'b1, 1'b1);   // C -> 48, held
      for (int i = 0; i < 5; i++) begin
         check("t7_stall_in_ready", 32'(in_ready), 32'd0);
         check("t7_stall_valid", 32'(out_valid), 32'd1);
         check("t7_stall_data", out_data, 32'd16);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("t7_release_in_ready", 32'(in_ready), 32'd1);
      tick();
      idle();
      check("t7_b_valid", 32'(out_valid), 32'd1);
      check("t7_b_data", out_data, 32'd32);
      tick();
      check("t7_c_valid", 32'(out_valid), 32'd1);
      check("t7_c_data", out_data, 32'd48);
      tick();
      check("t7_drained", 32'(out_valid), 32'd0);

      // T8: reset mid-window discards the partial sum
      set_beat(fill(6'd5), 12'h000, 16'h0000, 1'b1, 1'b0);
      tick();
      set_beat(fill(6'd5), 12'h000, 16'h0000, 1'b0, 1'b0);
      tick();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t8_rst_valid", 32'(out_valid), 32'd0);
      tick();
      tick();
      check("t8_no_output", 32'(out_valid), 32'd0);
      // A closing beat without first must see acc = 0
      set_beat(fill(6'd1), 12'h000, 16'h0000, 1'b0, 1'b1);
      tick();
      idle();
      tick();
      check("t8_last_only_valid", 32'(out_valid), 32'd1);
      check("t8_last_only_data", out_data, 32'd16);
      tick();
      set_beat(fill(6'd1), 12'h000, 16'h0000, 1'b1, 1'b1);
      tick();
      idle();
      tick();
      check("t8_fresh_valid", 32'(out_valid), 32'd1);
      check("t8_fresh_data", out_data, 32'd16);
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fusion_shift_accumulator.md
Name: fusion_shift_accumulator

Overview:
- Consumer end of the shift-lookup interface: takes the per-bitbrick row shift codes (row0..row3) and half-row big_shift codes, and applies them to 16 bitbrick partial products.
- Reduces the shifted products to one fused result per beat.
- Accumulates fused results over a first..last window and presents the sum on a valid/ready output.
- Sits between the 4x4 bitbrick array and the output buffer of a fusion unit.

Parameters:
- PROD_W, 6, signed width of one bitbrick product.
- ACC_W, 32, accumulator and output width (two's complement, wraps).
- PIPE_STAGES, 2, fixed; documented constant, not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid && in_ready
- products  in  16*PROD_W  brick b = row*4+col at [b*PROD_W +: PROD_W], signed
- row0..row3  in  12 each  shift codes for bricks of row r; col c uses bits [3c+2:3c]
- big_shift  in  16  eight 2-bit codes; half-row h = 2r+(col>>1) uses bits [2h+1:2h]
- first  in  1  beat starts a new accumulation window
- last  in  1  beat ends the window
- out_valid  out  1  result pending
- out_ready  in  1  downstream accepts
- out_data  out  ACC_W  accumulated result, signed

Behaviour:
- Single clock; reset is synchronous and active-high. Reset clears out_valid=0, out_data=0, accumulator=0, all pipe valids=0. in_ready=1 during and after reset.
- Stall rule: en = !(out_valid && !out_ready). in_ready = en. All pipe registers and the accumulator advance only when en=1.
- S1 (registered):
  - Each brick is sign-extended to ACC_W and shifted left by its 3-bit row code (0..7).
  - Half-row sums over cols {0,1} and {2,3} are formed, each shifted left by 4*big_shift code (0,4,8,12).
  - Result registered with first/last/valid.
- S2 (registered):
  - Adds the 8 half-row terms to form fused.
  - If first: acc <= fused. Otherwise acc <= acc + fused.
  - If last: out_data <= (first ? fused : acc+fused), out_valid <= 1, acc <= 0.
- Latency: accepted beat with last=1 produces out_valid=1 exactly 2 cycles later (no stall).
- Output handshake:
  - out_valid clears on out_valid && out_ready, unless a new last result lands in the same cycle; in that case out_valid stays 1 and out_data updates.
  - out_data is stable while out_valid && !out_ready.
- first && last on one beat: single-beat window, result = fused.
- Beat without first while no window is open: adds to acc, which is 0 after reset or after a last.
- Arithmetic: all sums are modulo 2^ACC_W (wrap, no saturation). A shifted term needs at most PROD_W+19 bits, which fits ACC_W.
- All-zero codes (the lookup default) give the plain signed sum of the 16 products.
- Bubbles: in_valid=0 beats leave acc unchanged.
- Reset mid-window: the partial acc is discarded and no output is produced for that window.

Decomposition:
- Package fusion_pkg holds NUM_BRICKS=16, ROW_CODE_W=3, BIG_CODE_W=2, BIG_SHIFT_UNIT=4, and a helper function decoding a brick index to its row/col/half-row.
- One natural sub-module: brick_shift_reduce. It is the combinational S1 datapath (16 shifts + 8 half-row sums), leaving the top with the pipeline, accumulator and handshake.

Test Plan:
- Reset, then all products=1, all codes 0, first=last=1 -> out_valid at cycle+2, out_data=16.
- Products all 1, row codes all 3'b010 (shift 2), big_shift=0, first=last=1 -> out_data=64.
- Only brick 15=-1, row3 col3 code 3'b110, big_shift[15:14]=2'b10, first=last=1 -> out_data=-(1<<14) (0xFFFFC000 at ACC_W=32).
- 3-beat window of products all 2 (first on beat 0, last on beat 2), codes 0 -> one output, out_data=96; no out_valid on beats 0-1.
- out_ready=0 for 5 cycles while out_valid=1 -> in_ready=0, out_data held; raise out_ready with the next last result already queued -> back-to-back results, none dropped.
- rst asserted after beat 1 of a 3-beat window -> no output. The next window (first=last=1, products all 1) gives 16, not a carried-over partial sum.
